// File: rtl/fetch_queue.sv
// fetch_queue: sram-like instruction fetcher feeding an in-order queue with redirect flush and AdEL entries.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [DEPTH-1:0] exc_q;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [OW-1:0] outs, disc;
  logic [31:0] fpc, resp_pc, pend_addr;
  logic pend, stale, halted;
  logic can_issue, hs, dec, push_data, push_exc, push, pop;
  // occupancy + outstanding bound guarantees every push finds a free slot
  assign can_issue = (32'(count) + 32'(outs) < 32'(DEPTH)) && (outs < OW'(MAX_OUTSTANDING)) &&
                     (fpc[1:0] == 2'b00) && !halted;
  assign inst_req = !rst && (pend || can_issue);
  assign inst_addr = pend ? pend_addr : fpc;
  assign inst_wr = 1'b0;
  assign inst_size = 2'b10;
  assign inst_wdata = 32'd0;
  assign hs = inst_req && inst_addr_ok;
  assign dec = inst_data_ok && (outs != '0);
  assign push_data = dec && (disc == '0) && !redirect;
  assign push_exc = (fpc[1:0] != 2'b00) && !pend && (disc == '0) && !halted && !redirect &&
                    !push_data && (count < CW'(DEPTH));
  assign push = push_data || push_exc;
  assign pop = out_valid && out_ready && !redirect;
  assign out_valid = !rst && (count != '0);
  assign out_pc = pc_q[head];
  assign out_inst = inst_q[head];
  assign out_exc = exc_q[head];
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail] <= push_exc ? fpc : resp_pc;
      inst_q[tail] <= push_exc ? 32'd0 : inst_rdata;
      exc_q[tail] <= push_exc;
    end
  end
  // a request caught by redirect stays pending (stale) and completes at its old address
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      outs <= '0;
      disc <= '0;
      pend <= 1'b0;
      stale <= 1'b0;
      halted <= 1'b0;
      fpc <= RESET_PC;
      resp_pc <= RESET_PC;
    end else begin
      pend <= inst_req && !inst_addr_ok;
      pend_addr <= inst_addr;
      outs <= outs + OW'(hs) - OW'(dec);
      if (redirect) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        fpc <= redirect_pc;
        resp_pc <= redirect_pc;
        halted <= 1'b0;
        stale <= inst_req && !inst_addr_ok;
        disc <= outs + OW'(inst_req) - OW'(dec);
      end else begin
        if (hs) stale <= 1'b0;
        if (hs && !stale) fpc <= fpc + 32'd4;
        if (dec && disc != '0) disc <= disc - OW'(1);
        if (push_data) resp_pc <= resp_pc + 32'd4;
        if (push_exc) halted <= 1'b1;
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of streaming, backpressure, redirect and AdEL behaviour.
module tb_fetch_queue;
  localparam logic [31:0] BFC = 32'hbfc00000;
  localparam logic [31:0] K = 32'h12345678;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic inst_req, inst_wr;
  logic [1:0] inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [31:0] inst_rdata = 32'd0;
  logic inst_addr_ok = 1'b0;
  logic inst_data_ok = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic out_exc;
  logic ack_en = 1'b0;
  logic dat_en = 1'b0;
  logic [31:0] rq[$];
  logic [31:0] hs_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic got_exc[$];
  int got_cyc[$];
  int hs_cnt = 0;
  int outs_tb = 0;
  int max_outs = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n0;
  fetch_queue dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      rq.delete();
      hs_q.delete();
      hs_cnt = 0;
      outs_tb = 0;
    end else begin
      if (inst_data_ok) begin
        rq.delete(0);
        outs_tb--;
      end
      if (inst_req && inst_addr_ok) begin
        rq.push_back(inst_addr);
        hs_q.push_back(inst_addr);
        hs_cnt++;
        outs_tb++;
      end
      if (outs_tb > max_outs) max_outs = outs_tb;
      if (out_valid && out_ready) begin
        got_pc.push_back(out_pc);
        got_inst.push_back(out_inst);
        got_exc.push_back(out_exc);
        got_cyc.push_back(cyc);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    inst_addr_ok = ack_en && inst_req;
    inst_data_ok = dat_en && rq.size() != 0;
    inst_rdata = rq.size() != 0 ? rq[0] ^ K : 32'd0;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_got();
    got_pc.delete();
    got_inst.delete();
    got_exc.delete();
    got_cyc.delete();
  endtask
  task automatic do_reset();
    ack_en = 1'b0;
    tick(4);
    rst = 1'b1;
    clear_got();
    tick(2);
    rst = 1'b0;
  endtask
  task automatic wait_got(input int n, input int bound);
    for (int i = 0; i < bound && got_pc.size() < n; i++) tick();
    chk("got_timeout", 32'(got_pc.size() >= n), 32'd1);
  endtask
  initial begin
    tick(3);
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #2;
    chk("first_req", 32'(inst_req), 32'd1);
    chk("first_addr", inst_addr, BFC);
    chk("inst_size", 32'(inst_size), 32'd2);
    ack_en = 1'b1;
    dat_en = 1'b1;
    out_ready = 1'b1;
    tick(12);
    chk("stream_n", 32'(got_pc.size() >= 8), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("stream_pc", got_pc[i], BFC + 32'(4 * i));
      chk("stream_inst", got_inst[i], (BFC + 32'(4 * i)) ^ K);
    end
    chk("stream_b2b", 32'(got_cyc[5] - got_cyc[0]), 32'd5);
    out_ready = 1'b0;
    do_reset();
    ack_en = 1'b1;
    tick(15);
    chk("bp_hs", 32'(hs_cnt), 32'd4);
    chk("bp_req", 32'(inst_req), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_pc, BFC);
    out_ready = 1'b1;
    tick(10);
    for (int i = 0; i < 6; i++) chk("bp_pc", got_pc[i], BFC + 32'(4 * i));
    chk("bp_inst", got_inst[3], 32'hbfc0000c ^ K);
    do_reset();
    ack_en = 1'b1;
    dat_en = 1'b0;
    for (int i = 0; i < 10 && hs_cnt < 2; i++) tick();
    chk("r42_hs2", 32'(hs_cnt), 32'd2);
    tick();
    chk("r42_req", 32'(inst_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h80001000;
    tick();
    redirect = 1'b0;
    chk("r42_flush", 32'(out_valid), 32'd0);
    clear_got();
    dat_en = 1'b1;
    wait_got(1, 20);
    chk("r42_pc", got_pc[0], 32'h80001000);
    chk("r42_inst", got_inst[0], 32'h80001000 ^ K);
    chk("r42_hs3", hs_q[2], 32'h80001000);
    do_reset();
    tick(2);
    redirect = 1'b1;
    redirect_pc = 32'h80002000;
    tick();
    redirect = 1'b0;
    chk("r43_req", 32'(inst_req), 32'd1);
    chk("r43_hold", inst_addr, BFC);
    tick(2);
    chk("r43_hold2", inst_addr, BFC);
    ack_en = 1'b1;
    wait_got(1, 20);
    chk("r43_hs0", hs_q[0], BFC);
    chk("r43_hs1", hs_q[1], 32'h80002000);
    chk("r43_pc", got_pc[0], 32'h80002000);
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80000002;
    tick();
    redirect = 1'b0;
    tick(8);
    chk("r44_valid", 32'(out_valid), 32'd1);
    chk("r44_pc", out_pc, 32'h80000002);
    chk("r44_exc", 32'(out_exc), 32'd1);
    chk("r44_inst", out_inst, 32'd0);
    n0 = hs_cnt;
    tick(6);
    chk("r44_nohs", 32'(hs_cnt), 32'(n0));
    chk("r44_req", 32'(inst_req), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("r44_single", 32'(out_valid), 32'd0);
    tick(4);
    chk("r44_halt", 32'(inst_req), 32'd0);
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80003000;
    tick();
    redirect = 1'b0;
    tick(8);
    redirect = 1'b1;
    redirect_pc = 32'h80005000;
    #2;
    chk("r45_dok", 32'(inst_data_ok), 32'd1);
    chk("r45_pop", 32'(out_valid && out_ready), 32'd1);
    n0 = got_pc.size();
    tick();
    redirect = 1'b0;
    chk("r45_flush", 32'(out_valid), 32'd0);
    chk("r45_popd", 32'(got_pc.size()), 32'(n0 + 1));
    wait_got(n0 + 2, 20);
    chk("r45_pc", got_pc[n0 + 1], 32'h80005000);
    chk("max_outs", 32'(max_outs), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
